// File: rtl/neuron_writeback.sv
// rtl/neuron_writeback.sv - buffers MAC results and writes them to consecutive neuron RAM addresses
// Optional ReLU on the RAM write side when NEURON_WB_RELU_EN is defined.
module neuron_writeback #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] write_base,
  input  logic [ADDR_W-1:0] count,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              ram_gnt,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q, count_q, acc_cnt, wr_cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    occ;
  logic              full, empty, push, pop, last_commit, done_nx, launch;
  logic [DATA_W-1:0] head, head_act;

  assign full  = (occ == DEPTH_L);
  assign empty = (occ == '0);
  assign busy  = (state == RUN);

  // Ready looks only at the full flag so a same-cycle pop never opens a slot.
  assign res_ready   = busy && !full && (acc_cnt < count_q);
  assign push        = res_valid && res_ready;
  assign ram_wre     = busy && !empty;
  assign pop         = ram_wre && ram_gnt;
  assign last_commit = pop && ((wr_cnt + ADDR_W'(1)) == count_q);
  assign launch      = (state == IDLE) && start && (count != '0);

  assign head = mem[rd_ptr];
`ifdef NEURON_WB_RELU_EN
  assign head_act = head[DATA_W-1] ? '0 : head;
`else
  assign head_act = head;
`endif
  // FIFO storage is unreset, so gate the data bus to keep it clean when idle.
  assign ram_wdata = ram_wre ? head_act : '0;
  assign ram_addr  = base_q + wr_cnt;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) state_nx = RUN;
          else             done_nx  = 1'b1;
        end
      end
      RUN: begin
        if (last_commit) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (launch) begin
        base_q  <= write_base;
        count_q <= count;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (push) acc_cnt <= acc_cnt + ADDR_W'(1);
        if (pop)  wr_cnt  <= wr_cnt + ADDR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_data;
  end

endmodule

// File: tb/tb_neuron_writeback.sv
// tb/tb_neuron_writeback.sv - vector table, directed sequences and random layers vs a queue model
// Expected write data follows NEURON_WB_RELU_EN the same way the design does.
module tb_neuron_writeback;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, start, res_valid, res_ready, ram_gnt, ram_wre, busy, done;
  logic [7:0] write_base, count, res_data, ram_addr, ram_wdata;

  always #5 clk = ~clk;

  neuron_writeback #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .write_base(write_base), .count(count),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .ram_gnt(ram_gnt), .ram_wre(ram_wre), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_wr = 0;

  bit         m_run, m_done;
  int         m_acc, m_wr, m_base, m_cnt;
  logic [7:0] m_q[$];

  typedef struct {
    logic s; logic [7:0] b; logic [7:0] c; logic v; logic [7:0] d; logic g;
    logic e_busy; logic e_ready; logic e_wre; logic [7:0] e_addr; logic [7:0] e_data; logic e_done;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [7:0] act(input logic [7:0] v);
`ifdef NEURON_WB_RELU_EN
    return v[7] ? 8'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    n_chk++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic [7:0] b, input logic [7:0] c,
                              input logic v, input logic [7:0] d, input logic g);
    bit pu, po;
    m_done = 0;
    if (r) begin
      m_run = 0; m_q.delete(); m_acc = 0; m_wr = 0; m_base = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (s) begin
        if (c != 0) begin
          m_run = 1; m_base = int'(b); m_cnt = int'(c); m_acc = 0; m_wr = 0;
        end else m_done = 1;
      end
    end else begin
      pu = v && (m_q.size() < DEPTH) && (m_acc < m_cnt);
      po = (m_q.size() > 0) && g;
      if (po) begin
        void'(m_q.pop_front());
        m_wr++;
        if (m_wr == m_cnt) begin m_run = 0; m_done = 1; end
      end
      if (pu) begin m_q.push_back(d); m_acc++; end
    end
  endtask

  task automatic check_model();
    bit e_wre;
    e_wre = m_run && (m_q.size() > 0);
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    chk("res_ready", int'(res_ready), int'(m_run && (m_q.size() < DEPTH) && (m_acc < m_cnt)));
    chk("ram_wre", int'(ram_wre), int'(e_wre));
    chk("ram_addr", int'(ram_addr), (m_base + m_wr) % 256);
    chk("ram_wdata", int'(ram_wdata), e_wre ? int'(act(m_q[0])) : 0);
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] b, input logic [7:0] c,
                      input logic v, input logic [7:0] d, input logic g);
    reset = r; start = s; write_base = b; count = c; res_valid = v; res_data = d; ram_gnt = g;
    #1;
    if (res_ready && res_valid && !r) n_acc++;
    if (ram_wre && ram_gnt && !r) n_wr++;
    @(posedge clk);
    model_update(r, s, b, c, v, d, g);
    #1;
    check_model();
  endtask

  task automatic run_to_idle(input int budget, input string name);
    int k = 0;
    while (m_run && k < budget) begin
      step(0, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      k++;
    end
    if (m_run) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    reset = 1'b1; start = 0; write_base = 0; count = 0; res_valid = 0; res_data = 0; ram_gnt = 0;
    step(1, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    chk("reset_addr", int'(ram_addr), 0);

    // Basic layer: base 10, count 3, results 5,7,9 with grant held high.
    tbl[0] = '{1'b1, 8'd10, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd10, 8'd0, 1'b0};
    tbl[1] = '{1'b0, 8'd0,  8'd0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1, 8'd10, 8'd5, 1'b0};
    tbl[2] = '{1'b0, 8'd0,  8'd0, 1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 1'b1, 8'd11, 8'd7, 1'b0};
    tbl[3] = '{1'b0, 8'd0,  8'd0, 1'b1, 8'd9, 1'b1, 1'b1, 1'b0, 1'b1, 8'd12, 8'd9, 1'b0};
    tbl[4] = '{1'b0, 8'd0,  8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd13, 8'd0, 1'b1};
    tbl[5] = '{1'b0, 8'd0,  8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd13, 8'd0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(0, tbl[i].s, tbl[i].b, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].g);
      chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
      chk("tbl_ready", int'(res_ready), int'(tbl[i].e_ready));
      chk("tbl_wre", int'(ram_wre), int'(tbl[i].e_wre));
      chk("tbl_addr", int'(ram_addr), int'(tbl[i].e_addr));
      chk("tbl_data", int'(ram_wdata), int'(tbl[i].e_data));
      chk("tbl_done", int'(done), int'(tbl[i].e_done));
    end

    // Backpressure: grant low for 8 cycles, only DEPTH results fit.
    step(0, 1, 8'd40, 8'd6, 1'b0, 8'd0, 1'b0);
    n_acc = 0; n_wr = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 8'd0, 8'd0, 1'b1, 8'(8'h10 + i), 1'b0);
    chk("bp_accepts", n_acc, 4);
    chk("bp_writes", n_wr, 0);
    chk("bp_addr_held", int'(ram_addr), 40);
    chk("bp_data_held", int'(ram_wdata), 16);
    for (int i = 0; i < 20 && m_run; i++) step(0, 0, 8'd0, 8'd0, 1'b1, 8'(8'h20 + i), 1'b1);
    chk("bp_total_writes", n_wr, 6);
    run_to_idle(10, "bp");
    step(0, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);

    // Address wrap and activation of a negative result.
    step(0, 1, 8'd254, 8'd3, 1'b0, 8'd0, 1'b1);
    step(0, 0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b1);
    chk("wrap_a0", int'(ram_addr), 254);
    step(0, 0, 8'd0, 8'd0, 1'b1, 8'hFE, 1'b1);
    chk("wrap_a1", int'(ram_addr), 255);
`ifdef NEURON_WB_RELU_EN
    chk("wrap_d1", int'(ram_wdata), 0);
`else
    chk("wrap_d1", int'(ram_wdata), 254);
`endif
    step(0, 0, 8'd0, 8'd0, 1'b1, 8'd4, 1'b1);
    chk("wrap_a2", int'(ram_addr), 0);
    run_to_idle(10, "wrap");
    step(0, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);

    // Extra results beyond count are refused.
    n_acc = 0; n_wr = 0;
    step(0, 1, 8'd70, 8'd2, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'd0, 8'd0, 1'b1, 8'(i + 1), 1'b1);
    run_to_idle(10, "extra");
    chk("extra_accepts", n_acc, 2);
    chk("extra_writes", n_wr, 2);

    // Zero count, then an ignored start during RUN.
    step(0, 1, 8'd90, 8'd0, 1'b0, 8'd0, 1'b1);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    step(0, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
    step(0, 1, 8'd50, 8'd2, 1'b0, 8'd0, 1'b1);
    step(0, 1, 8'd99, 8'd7, 1'b1, 8'd11, 1'b1);
    step(0, 1, 8'd99, 8'd7, 1'b1, 8'd12, 1'b1);
    chk("ign_addr", int'(ram_addr), 51);
    run_to_idle(10, "ign");
    step(0, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);

    // Reset after two commits, then a fresh single-result layer.
    n_wr = 0;
    step(0, 1, 8'd30, 8'd5, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'd0, 8'd0, 1'b1, 8'(8'h40 + i), 1'b1);
    chk("rst_commits", n_wr, 2);
    step(1, 0, 8'd0, 8'd0, 1'b1, 8'h55, 1'b1);
    chk("rst_wre", int'(ram_wre), 0);
    chk("rst_addr", int'(ram_addr), 0);
    step(0, 1, 8'd20, 8'd1, 1'b0, 8'd0, 1'b1);
    step(0, 0, 8'd0, 8'd0, 1'b1, 8'h33, 1'b1);
    chk("post_rst_addr", int'(ram_addr), 20);
    run_to_idle(10, "post_rst");
    step(0, 0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);

    // Random layers with random valid, grant and stray starts.
    for (int l = 0; l < 25; l++) begin
      step(0, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 12)), 1'b0, 8'd0, 1'($urandom % 2));
      for (int k = 0; k < 300 && m_run; k++)
        step(0, 1'($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom), 1'($urandom % 2),
             8'($urandom), 1'($urandom_range(0, 3) != 0));
      if (m_run) chk("rand_timeout", 1, 0);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        step(0, 0, 8'd0, 8'd0, 1'($urandom % 2), 8'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_writeback.md
# neuron_writeback

Write-side engine for the neuron dual-port RAM. Accepts finished neuron sums from the MAC core over a valid/ready handshake, buffers them in a small FIFO, optionally applies ReLU, and writes them to consecutive neuron RAM addresses starting at a per-layer write base. It is the counterpart of the address generator's read path: that path streams operands out of RAM into the MAC, and this block streams MAC results back into RAM. It pulses `done` once a layer's Nk outputs are committed.

## Interface
- `DATA_W`, 8: neuron value width, two's complement.
- `ADDR_W`, 8: neuron RAM address width.
- `FIFO_DEPTH`, 4: result buffer entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin layer; samples `write_base` and `count`.
- `write_base`  in  ADDR_W  first RAM address for this layer.
- `count`  in  ADDR_W  Nk, the number of results to write.
- `res_valid`  in  1  MAC result available.
- `res_data`  in  DATA_W  MAC result, signed.
- `res_ready`  out  1  block accepts `res_data` this cycle.
- `ram_gnt`  in  1  RAM write port granted this cycle.
- `ram_wre`  out  1  write request to neuron RAM.
- `ram_addr`  out  ADDR_W  write address.
- `ram_wdata`  out  DATA_W  write data.
- `busy`  out  1  layer in progress.
- `done`  out  1  one-cycle pulse, layer complete.

## Operation
- States: IDLE and RUN.
- IDLE, `start`=1, `count`≠0: latch base and count, clear `acc_cnt`/`wr_cnt`, go to RUN.
- IDLE, `start`=1, `count`=0: stay in IDLE; `done` pulses next cycle.
- `start` in RUN is ignored.
- Accept: `res_ready` = RUN && !full && `acc_cnt`<count. A push occurs on `res_valid && res_ready` and increments `acc_cnt`. `res_ready` depends on the full flag only; a simultaneous pop does not open a slot that cycle.
- Write: `ram_wre` = RUN && !empty. `ram_wdata` is the FIFO head after activation. `ram_addr` = base + `wr_cnt`, modulo 2^ADDR_W, so wrap past the top address is legal and silent.
- A write commits on `ram_wre && ram_gnt`. It pops the FIFO and increments `wr_cnt`.
- `ram_gnt` low holds `ram_wre`, `ram_addr` and `ram_wdata` stable.
- When the commit makes `wr_cnt`==count: go to IDLE; `done`=1 in the following cycle.
- Simultaneous push and pop leave occupancy unchanged, and both counters advance.
- Results offered after `acc_cnt` reaches count are not accepted (`res_ready`=0).
- Reset at any time, including mid-layer: FIFO emptied, counters zeroed, state IDLE. Partially written results stay in RAM and are not undone.
- Reset values: `res_ready`=0, `ram_wre`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `done`=0.
- `busy` = RUN.

## Timing
- `start` at edge E gives `busy`=1 and `res_ready`=1 after E.
- A result pushed at edge N appears on `ram_wre`/`ram_wdata` in cycle N+1. It commits at edge N+1 if `ram_gnt`=1.
- Sustained throughput is 1 result/cycle with `ram_gnt` held high.
- `done` is asserted in the cycle after the final commit and lasts exactly one cycle. `busy` falls in that same cycle.
- `count`=0: `done` is high in the cycle after the `start` edge.
- No combinational path from `res_valid` to `ram_*`. `ram_gnt` affects only internal pop and counters.

## Configuration
- `NEURON_WB_RELU_EN` defined: a head value with MSB=1 is written as 0; non-negative values pass unchanged.
- `NEURON_WB_RELU_EN` undefined: values are written unchanged (identity activation).
- FIFO contents are always raw; activation is applied on the read side only.

## Test plan
- Basic layer: base=10, count=3, results 5,7,9 back-to-back, `ram_gnt`=1 → writes (10,5),(11,7),(12,9) on consecutive cycles; `done` pulses once in the cycle after the (12,9) write; `busy` then 0.
- Backpressure: FIFO_DEPTH=4, count=6, `ram_gnt`=0 for 8 cycles → `res_ready` drops after 4 accepts; `ram_wre`=1 with addr=base and data held for all 8 cycles; after `ram_gnt`=1, all 6 write in order with no loss.
- Wrap and activation: base=254, count=3, results 3,−2(0xFE),4 → addresses 254,255,0. Data is 3,0,4 with RELU_EN and 3,0xFE,4 without.
- Extra results: count=2, source offers 4 results → only 2 accepted and written; `res_ready`=0 afterwards; `done` pulses once.
- Zero count / ignored start: `start` with count=0 → no `ram_wre`, `done` in next cycle. A second `start` during RUN does not change base or count.
- Reset mid-layer: count=5, reset after 2 commits → next cycle all outputs 0, FIFO empty. A new start with base=20, count=1 writes (20,x) correctly.
